rnf_txreq: RTL and testbench
============================

Name: rnf_txreq

Overview:
CHI REQ-channel link-layer transmitter on the RNF side. It feeds the HNF RXREQ receiver and terminates its L-credit return. Request flits from the RNF core are buffered in a local FIFO and issued on TXREQFLIT with a one-cycle FLITPEND lead. Each flit consumes one L-credit granted by TXREQLCRDV. A stop/drain handshake quiesces the link.

Parameters:
QDEPTH, 4, depth of local request FIFO (power of 2, >=2)
MAX_CRD, 15, L-credit counter saturation value (CHI maximum 15)
CRD_W, 4, credit counter width, must hold MAX_CRD

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req_flit  input  $bits(reqflit_t)  request flit from RNF core
req_valid  input  1  req_flit valid
req_ready  output  1  FIFO can accept; push = req_valid & req_ready
TXREQFLIT  output  $bits(reqflit_t)  flit to HNF RXREQFLIT
TXREQFLITV  output  1  flit valid this cycle
TXREQFLITPEND  output  1  flit will be valid next cycle
TXREQLCRDV  input  1  one L-credit granted per cycle high
txreq_stop  input  1  level request to stop issuing
txreq_stopped  output  1  link quiescent (no PEND, no V outstanding)
crd_overflow  output  1  sticky: credit received while counter at MAX_CRD
crd_cnt  output  CRD_W  current unreserved L-credit count (debug)

Behaviour:
- Reset values: req_ready=0 while reset high, then 1; TXREQFLITV=0; TXREQFLITPEND=0; TXREQFLIT=0; txreq_stopped=0; crd_overflow=0; crd_cnt=0; FIFO empty; FSM=RUN.
- FIFO: push on req_valid&req_ready; req_ready = ~full. Simultaneous push and pop at full is not allowed (req_ready=0 when full). Pointers wrap mod QDEPTH.
- pend_q: register of TXREQFLITPEND. TXREQFLITV = pend_q. TXREQFLIT = FIFO head while pend_q=1, else 0. FIFO pop occurs in every cycle with TXREQFLITV=1.
- avail = fifo_count - pend_q (entries not yet reserved).
- TXREQFLITPEND (combinational) = (state==RUN) & (crd_cnt!=0) & (avail!=0).
- Credit: crd_cnt_next = crd_cnt + TXREQLCRDV - TXREQFLITPEND. PEND reserves the credit in its own cycle. When grant and PEND coincide, crd_cnt is unchanged. A grant at crd_cnt==MAX_CRD without simultaneous PEND is dropped and sets crd_overflow (cleared only by reset).
- Throughput: back-to-back one flit/cycle when credits and entries allow. Latency push→TXREQFLITV minimum 2 cycles: push at t, PEND at t+1, V at t+2.
- FSM:
  - RUN: normal issue. txreq_stop=1 → DRAIN. PEND is suppressed from that cycle onward.
  - DRAIN: no new PEND. Outstanding V (pend_q) completes. When pend_q==0 → STOPPED.
  - STOPPED: txreq_stopped=1. FIFO still accepts pushes. Credits still accumulate. txreq_stop=0 → RUN; txreq_stopped drops in the same transition.
  - Stop deasserted while in DRAIN → RUN directly.
- Asynchronous reset mid-transfer drops any pending V without completion. Credits are lost; the receiver is reset together with this block.

Optional Feature:
RNF_TXREQ_STATS_EN
- Defined: adds outputs stat_flits[31:0] and stat_crd_stall[31:0]. stat_flits counts cycles with TXREQFLITV=1. stat_crd_stall counts cycles with state==RUN & avail!=0 & crd_cnt==0. Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, crd_cnt=0, push 1 flit (Addr=0x1000) → no PEND. Grant 1 credit at t → PEND at t+1, V with Addr=0x1000 at t+2, crd_cnt back to 0.
- Grant 4 credits, push 4 flits back-to-back → PEND high 4 consecutive cycles, V 4 consecutive cycles one cycle later, in push order, FIFO empty after.
- Fill FIFO (4 pushes, 0 credits) → req_ready=0. 5th req_valid held; grant 1 credit → req_ready=1 in the cycle after the first pop.
- Hold TXREQLCRDV=1 for 16 cycles with empty FIFO → crd_cnt saturates at 15, crd_overflow=1 and stays set.
- Credits=3, FIFO=3 entries, assert txreq_stop in the cycle after the first PEND → exactly 1 V issued, txreq_stopped=1 one cycle after that V, crd_cnt=2. Release stop → remaining 2 flits issue.
- Assert reset with pend_q=1 → TXREQFLITV=0 and FLITPEND=0 immediately, crd_cnt=0, FIFO empty.

Source files
------------

// File: rtl/rnf_txreq.sv
// CHI REQ-channel link-layer transmitter (RNF side): local request FIFO, L-credit
// accounting, FLITPEND lead and stop/drain handshake. Optional counters: RNF_TXREQ_STATS_EN.
module rnf_txreq #(
    parameter int QDEPTH  = 4,
    parameter int MAX_CRD = 15,
    parameter int CRD_W   = 4,
    // Width of the request flit (reqflit_t packed as a flat vector)
    parameter int FLIT_W  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FLIT_W-1:0] req_flit,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [FLIT_W-1:0] TXREQFLIT,
    output logic              TXREQFLITV,
    output logic              TXREQFLITPEND,
    input  logic              TXREQLCRDV,
    input  logic              txreq_stop,
    output logic              txreq_stopped,
    output logic              crd_overflow,
`ifdef RNF_TXREQ_STATS_EN
    output logic [31:0]       stat_flits,
    output logic [31:0]       stat_crd_stall,
`endif
    output logic [CRD_W-1:0]  crd_cnt
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_STOPPED} state_t;

    state_t             state_q, state_d;
    logic [FLIT_W-1:0]  mem_q [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pend_q;
    logic [CRD_W-1:0]   crd_q, crd_d;
    logic               ovf_q, ovf_d;

    logic               full, push, pop, pend;
    logic [CNT_W-1:0]   avail;

    assign full      = (count_q == CNT_W'(QDEPTH));
    assign req_ready = ~reset & ~full;
    assign push      = req_valid & req_ready;
    // The flit shown on TXREQFLIT leaves the FIFO in the same cycle it is valid
    assign pop       = pend_q;
    assign avail     = count_q - CNT_W'(pend_q);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // PEND reserves a credit in its own cycle; a lone grant at saturation is dropped
    always_comb begin
        crd_d = crd_q;
        ovf_d = ovf_q;
        case ({TXREQLCRDV, pend})
            2'b10: begin
                if (crd_q == CRD_W'(MAX_CRD)) ovf_d = 1'b1;
                else                          crd_d = crd_q + 1'b1;
            end
            2'b01:   crd_d = crd_q - 1'b1;
            default: crd_d = crd_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            crd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pend_q   <= pend;
            crd_q    <= crd_d;
            ovf_q    <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= req_flit;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (txreq_stop) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!txreq_stop)  state_d = ST_RUN;
                else if (!pend_q) state_d = ST_STOPPED;
            end
            ST_STOPPED: if (!txreq_stop) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // A stop request masks PEND in the very cycle it is raised
    always_comb begin
        pend          = (state_q == ST_RUN) & ~txreq_stop & (crd_q != '0) & (avail != '0);
        txreq_stopped = (state_q == ST_STOPPED) | ((state_q == ST_DRAIN) & ~pend_q);
        TXREQFLIT     = pend_q ? mem_q[rd_ptr_q] : '0;
    end

    assign TXREQFLITPEND = pend;
    assign TXREQFLITV    = pend_q;
    assign crd_overflow  = ovf_q;
    assign crd_cnt       = crd_q;

`ifdef RNF_TXREQ_STATS_EN
    logic [31:0] stat_flits_q, stat_stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_flits_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (pend_q) stat_flits_q <= stat_flits_q + 32'd1;
            if ((state_q == ST_RUN) && (avail != '0) && (crd_q == '0))
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_flits     = stat_flits_q;
    assign stat_crd_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_rnf_txreq.sv
// Self-checking bench for rnf_txreq: directed link scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_rnf_txreq;

    localparam int QD   = 4;
    localparam int MAXC = 15;
    localparam int FW   = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] req_flit = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [FW-1:0] TXREQFLIT;
    logic          TXREQFLITV, TXREQFLITPEND;
    logic          TXREQLCRDV = 1'b0;
    logic          txreq_stop = 1'b0;
    logic          txreq_stopped, crd_overflow;
    logic [3:0]    crd_cnt;
`ifdef RNF_TXREQ_STATS_EN
    logic [31:0]   stat_flits, stat_crd_stall;
`endif

    rnf_txreq #(.QDEPTH(QD), .MAX_CRD(MAXC), .CRD_W(4), .FLIT_W(FW)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_flit      (req_flit),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .TXREQFLIT     (TXREQFLIT),
        .TXREQFLITV    (TXREQFLITV),
        .TXREQFLITPEND (TXREQFLITPEND),
        .TXREQLCRDV    (TXREQLCRDV),
        .txreq_stop    (txreq_stop),
        .txreq_stopped (txreq_stopped),
        .crd_overflow  (crd_overflow),
`ifdef RNF_TXREQ_STATS_EN
        .stat_flits    (stat_flits),
        .stat_crd_stall(stat_crd_stall),
`endif
        .crd_cnt       (crd_cnt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, whether the head is on the wire, credit pool,
    // and link mode (0 run, 1 draining, 2 stopped).
    logic [63:0] m_fifo[$];
    bit          m_onwire;
    int          m_crd;
    bit          m_ovf;
    int          m_mode;
    longint      m_flits, m_stall;
    int          vcount;

    task automatic model_reset();
        m_fifo.delete();
        m_onwire = 0;
        m_crd    = 0;
        m_ovf    = 0;
        m_mode   = 0;
        m_flits  = 0;
        m_stall  = 0;
    endtask

    // One clock cycle: compare outputs against the model, then advance the model.
    task automatic cycle();
        bit          e_ready, e_pend, e_stopped;
        int          unres, n;
        logic [63:0] e_flit;
        #1;
        unres     = m_fifo.size() - int'(m_onwire);
        e_ready   = (m_fifo.size() < QD);
        e_pend    = (m_mode == 0) && !txreq_stop && (m_crd > 0) && (unres > 0);
        e_stopped = (m_mode == 2) || (m_mode == 1 && !m_onwire);
        e_flit    = m_onwire ? m_fifo[0] : 64'h0;
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("flitv",     64'(TXREQFLITV), 64'(m_onwire));
        check("flitpend",  64'(TXREQFLITPEND), 64'(e_pend));
        check("flit",      TXREQFLIT, e_flit);
        check("stopped",   64'(txreq_stopped), 64'(e_stopped));
        check("crd_cnt",   64'(crd_cnt), 64'(m_crd));
        check("overflow",  64'(crd_overflow), 64'(m_ovf));
`ifdef RNF_TXREQ_STATS_EN
        check("stat_flits", 64'(stat_flits), 64'(m_flits[31:0]));
        check("stat_stall", 64'(stat_crd_stall), 64'(m_stall[31:0]));
`endif
        if (m_onwire) $display("flit #%0d issued: %h", vcount, e_flit);
        @(posedge clock);
        m_flits += longint'(m_onwire);
        if (m_mode == 0 && unres > 0 && m_crd == 0) m_stall++;
        if (m_onwire) begin
            void'(m_fifo.pop_front());
            vcount++;
        end
        if (req_valid && e_ready) m_fifo.push_back(req_flit);
        n = m_crd + int'(TXREQLCRDV) - int'(e_pend);
        if (n > MAXC) m_ovf = 1;
        else          m_crd = n;
        case (m_mode)
            0: if (txreq_stop) m_mode = 1;
            1: if (!txreq_stop) m_mode = 0; else if (!m_onwire) m_mode = 2;
            default: if (!txreq_stop) m_mode = 0;
        endcase
        m_onwire = e_pend;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    int v0;

    initial begin
        model_reset();
        vcount = 0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_ready",   64'(req_ready), 64'h0);
        check("rst_flitv",   64'(TXREQFLITV), 64'h0);
        check("rst_pend",    64'(TXREQFLITPEND), 64'h0);
        check("rst_flit",    TXREQFLIT, 64'h0);
        check("rst_stopped", 64'(txreq_stopped), 64'h0);
        check("rst_ovf",     64'(crd_overflow), 64'h0);
        check("rst_crd",     64'(crd_cnt), 64'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single flit waits for its credit, then PEND, then V
        req_flit = 64'h1000; req_valid = 1'b1; cycle(); req_valid = 1'b0;
        cycle();
        TXREQLCRDV = 1'b1; cycle(); TXREQLCRDV = 1'b0;
        #1 check("s1_pend", 64'(TXREQFLITPEND), 64'h1);
        cycle();
        #1;
        check("s1_v",    64'(TXREQFLITV), 64'h1);
        check("s1_addr", TXREQFLIT, 64'h1000);
        check("s1_crd",  64'(crd_cnt), 64'h0);
        cycle();

        // Four credits, four back-to-back pushes
        TXREQLCRDV = 1'b1; repeat (4) cycle(); TXREQLCRDV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_flit = 64'h2000 + 64'(i); cycle();
        end
        req_valid = 1'b0;
        repeat (4) cycle();

        // Fill with no credits; held 5th request enters after the first pop
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_flit = 64'h3000 + 64'(i); cycle();
        end
        req_flit = 64'h3004;
        #1 check("s3_full", 64'(req_ready), 64'h0);
        cycle();
        TXREQLCRDV = 1'b1; cycle(); TXREQLCRDV = 1'b0;
        cycle(); cycle();
        #1 check("s3_ready_back", 64'(req_ready), 64'h1);
        cycle();
        req_valid = 1'b0;
        TXREQLCRDV = 1'b1; repeat (5) cycle(); TXREQLCRDV = 1'b0;
        repeat (4) cycle();

        // Credit saturation and sticky overflow
        TXREQLCRDV = 1'b1; repeat (16) cycle(); TXREQLCRDV = 1'b0;
        #1;
        check("s4_crd", 64'(crd_cnt), 64'd15);
        check("s4_ovf", 64'(crd_overflow), 64'h1);
        repeat (3) cycle();
        #1 check("s4_ovf_sticky", 64'(crd_overflow), 64'h1);

        // Stop raised the cycle after the first PEND
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_flit = 64'h5000 + 64'(i); cycle();
        end
        req_valid = 1'b0;
        v0 = vcount;
        TXREQLCRDV = 1'b1; cycle();
        cycle();
        txreq_stop = 1'b1;
        #1 check("s5_pend_masked", 64'(TXREQFLITPEND), 64'h0);
        cycle();
        TXREQLCRDV = 1'b0;
        #1;
        check("s5_stopped", 64'(txreq_stopped), 64'h1);
        check("s5_crd",     64'(crd_cnt), 64'd2);
        repeat (4) cycle();
        check("s5_one_v", 64'(vcount - v0), 64'd1);
        txreq_stop = 1'b0;
        repeat (6) cycle();
        check("s5_rest_v", 64'(vcount - v0), 64'd3);

        // Asynchronous reset while a flit is on the wire
        req_valid = 1'b1; req_flit = 64'h6000; cycle(); req_valid = 1'b0;
        TXREQLCRDV = 1'b1; cycle(); TXREQLCRDV = 1'b0;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check("s6_v",     64'(TXREQFLITV), 64'h0);
        check("s6_pend",  64'(TXREQFLITPEND), 64'h0);
        check("s6_crd",   64'(crd_cnt), 64'h0);
        check("s6_ready", 64'(req_ready), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        cycle();

        // Random traffic with occasional stop requests
        for (int c = 0; c < 800; c++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_flit   = {$urandom(), $urandom()};
            TXREQLCRDV = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) txreq_stop = ~txreq_stop;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
